cost_row_arb: RTL and testbench

COST_ROW_ARB -- requirements
Module: cost_row_arb

---
 rtl/cost_row_arb.sv | 167 ++++++++++++++++
 tb/tb_cost_row_arb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cost_row_arb.sv
// -----------------------------------------------------------------------------
// cost_row_arb
//
// Shares one combinational cost-ROM read port between two requesters. Each
// grant is served as an 8-beat row read: the winner's row is latched into W,
// J sweeps 0..7, and every ROM word is registered onto the rd_* beat bus one
// cycle later. The registered row_sum carries the running sum of the row and
// is meaningful on the beat flagged by rd_last.
//
// Arbitration happens when the block is idle, or on the edge that ends beat 7
// of a burst. That second case lets a waiting requester start its row with no
// bubble after the previous row. When both requesters ask at once, the
// round-robin priority holder wins, and priority then moves to the other one.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   synchronous, active-high reset
//   req[1:0]  in   level request per requester, held until its gnt bit is seen
//   row0[2:0] in   worker row for requester 0, sampled at its grant edge
//   row1[2:0] in   worker row for requester 1, sampled at its grant edge
//   gnt[1:0]  out  one-hot grant pulse, high for the first burst cycle only
//   W[2:0]    out  worker index to the cost ROM (0 while idle)
//   J[2:0]    out  job index to the cost ROM (0 while idle)
//   Cost[6:0] in   ROM data for the current W/J, valid in the same cycle
//   rd_valid  out  beat valid
//   rd_id     out  owner of the current beat
//   rd_beat   out  job index of the current beat
//   rd_data   out  registered Cost
//   rd_last   out  final beat (J==7) of a row
//   row_sum   out  sum of the 8 row costs, valid with rd_last
//   busy      out  high while a burst is in progress
// -----------------------------------------------------------------------------
module cost_row_arb #(
  parameter int PRIO_RESET = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic [2:0] row0,
  input  logic [2:0] row1,
  output logic [1:0] gnt,
  output logic [2:0] W,
  output logic [2:0] J,
  input  logic [6:0] Cost,
  output logic       rd_valid,
  output logic       rd_id,
  output logic [2:0] rd_beat,
  output logic [6:0] rd_data,
  output logic       rd_last,
  output logic [9:0] row_sum,
  output logic       busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [2:0] LAST_J = 3'd7;

  logic [0:0] state;
  logic       prio;      // requester that wins a simultaneous request
  logic       owner;     // requester being served by the current burst
  logic [9:0] acc;       // sum of the beats already registered for this row

  logic       in_burst;
  logic       last_beat;
  logic       arb_en;
  logic       grant;
  logic       winner;
  logic [2:0] win_row;
  logic [9:0] sum_next;

  // ---------------------------------------------------------------------------
  // Arbitration and datapath helpers
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a value on every path (defaults first),
  // so the block stays purely combinational and no latch is inferred.
  always_comb begin
    in_burst  = (state == S_BURST);
    last_beat = in_burst && (J == LAST_J);

    // The owner's own req is only looked at on the beat-7 edge; before that it
    // cannot win because arbitration is simply not enabled.
    arb_en = !in_burst || last_beat;
    grant  = arb_en && (req != 2'b00);

    winner = 1'b0;
    if (req == 2'b11) begin
      winner = prio;
    end else begin
      winner = req[1];
    end

    win_row  = winner ? row1 : row0;
    sum_next = acc + 10'(Cost);
  end

  assign busy = in_burst;

  // ---------------------------------------------------------------------------
  // Control: state, ROM address, ownership, priority and grant pulse
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      W     <= 3'd0;
      J     <= 3'd0;
      owner <= 1'b0;
      prio  <= PRIO_RESET[0];
      gnt   <= 2'b00;
    end else begin
      gnt <= 2'b00;
      if (grant) begin
        // The row is captured here, so later row0/row1 changes cannot reach
        // the burst in progress.
        state <= S_BURST;
        W     <= win_row;
        J     <= 3'd0;
        owner <= winner;
        prio  <= ~winner;
        gnt   <= winner ? 2'b10 : 2'b01;
      end else if (in_burst) begin
        if (J == LAST_J) begin
          state <= S_IDLE;
          W     <= 3'd0;
          J     <= 3'd0;
        end else begin
          J <= J + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-beat pipeline: one register stage behind the ROM address
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_id    <= 1'b0;
      rd_beat  <= 3'd0;
      rd_data  <= 7'd0;
      row_sum  <= 10'd0;
      acc      <= 10'd0;
    end else begin
      rd_valid <= in_burst;
      rd_last  <= last_beat;
      if (in_burst) begin
        rd_id   <= owner;
        rd_beat <= J;
        rd_data <= Cost;
        row_sum <= sum_next;
      end
      // A back-to-back grant lands on the same edge as beat 7 of the previous
      // row: row_sum still takes that beat (above), while the accumulator
      // restarts empty for the new row.
      if (grant) begin
        acc <= 10'd0;
      end else if (in_burst) begin
        acc <= sum_next;
      end
    end
  end

endmodule

// File: tb/tb_cost_row_arb.sv
// -----------------------------------------------------------------------------
// tb_cost_row_arb
//
// Bench for cost_row_arb. A ROM with Cost = 8*W + J (or a constant 127) sits
// on the W/J address. The reference model tracks the arbiter at transaction
// level: the current burst is (owner, row, beat number), priority is a single
// requester index, and the expected beat data and row sums are computed
// straight from the ROM formula. Outputs are compared on every falling edge.
// -----------------------------------------------------------------------------
module tb_cost_row_arb;

  localparam int PRIO = 0;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] req;
  logic [2:0] row0;
  logic [2:0] row1;
  logic [1:0] gnt;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       rd_valid;
  logic       rd_id;
  logic [2:0] rd_beat;
  logic [6:0] rd_data;
  logic       rd_last;
  logic [9:0] row_sum;
  logic       busy;

  bit force127 = 1'b0;

  cost_row_arb #(.PRIO_RESET(PRIO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .req      (req),
    .row0     (row0),
    .row1     (row1),
    .gnt      (gnt),
    .W        (W),
    .J        (J),
    .Cost     (Cost),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .rd_beat  (rd_beat),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .row_sum  (row_sum),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  assign Cost = force127 ? 7'd127 : 7'(8 * int'(W) + int'(J));

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int rom(input int w, input int j);
    return force127 ? 127 : 8 * w + j;
  endfunction

  function automatic int row_total(input int w);
    int s = 0;
    for (int j = 0; j < 8; j++) s += rom(w, j);
    return s;
  endfunction

  int m_busy, m_owner, m_row, m_beat, m_prio, m_sum_chk;
  int e_gnt, e_valid, e_id, e_beat, e_data, e_last, e_sum;

  task automatic model_step(input logic [1:0] r, input logic [2:0] a, b,
                            input logic rs);
    int win;
    if (rs) begin
      m_busy = 0; m_owner = 0; m_row = 0; m_beat = 0; m_prio = PRIO;
      e_gnt = 0; e_valid = 0; e_id = 0; e_beat = 0; e_data = 0;
      e_last = 0; e_sum = 0; m_sum_chk = 1;
      return;
    end
    // beat produced by this edge
    if (m_busy != 0) begin
      e_valid = 1; e_id = m_owner; e_beat = m_beat;
      e_data  = rom(m_row, m_beat);
      e_last  = (m_beat == 7) ? 1 : 0;
      if (e_last != 0) e_sum = row_total(m_row);
    end else begin
      e_valid = 0; e_last = 0;
    end
    // next burst
    e_gnt = 0;
    if ((m_busy == 0 || m_beat == 7) && r != 2'b00) begin
      if (r == 2'b11) win = m_prio;
      else            win = r[1] ? 1 : 0;
      e_gnt   = (win == 1) ? 2 : 1;
      m_prio  = 1 - win;
      m_owner = win;
      m_row   = (win == 1) ? int'(b) : int'(a);
      m_beat  = 0;
      m_busy  = 1;
      m_sum_chk = 0;
    end else if (m_busy != 0) begin
      if (m_beat == 7) begin
        m_busy = 0; m_beat = 0; m_row = 0;
      end else begin
        m_beat++;
      end
    end
  endtask

  // Observed-value records for the directed scenarios.
  int rec_sum[$];
  int rec_id[$];
  int rec_gnt[$];
  int rec_data[$];
  int cnt_busy;

  task automatic clear_rec();
    rec_sum.delete(); rec_id.delete(); rec_gnt.delete(); rec_data.delete();
    cnt_busy = 0;
  endtask

  task automatic compare_all();
    check("gnt",      int'(gnt),      e_gnt);
    check("W",        int'(W),        (m_busy != 0) ? m_row  : 0);
    check("J",        int'(J),        (m_busy != 0) ? m_beat : 0);
    check("busy",     int'(busy),     m_busy);
    check("rd_valid", int'(rd_valid), e_valid);
    check("rd_last",  int'(rd_last),  e_last);
    check("rd_id",    int'(rd_id),    e_id);
    check("rd_beat",  int'(rd_beat),  e_beat);
    check("rd_data",  int'(rd_data),  e_data);
    if (e_last != 0 || m_sum_chk != 0) check("row_sum", int'(row_sum), e_sum);
    if (rd_last)    begin rec_sum.push_back(int'(row_sum)); rec_id.push_back(int'(rd_id)); end
    if (gnt != 2'b00) rec_gnt.push_back(int'(gnt));
    if (rd_valid)   rec_data.push_back(int'(rd_data));
    if (busy)       cnt_busy++;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic tick(input logic [1:0] r, input logic [2:0] a, b, input logic rs);
    req = r; row0 = a; row1 = b; RST = rs;
    model_step(r, a, b, rs);
    @(posedge CLK);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    tick(2'b00, 3'd0, 3'd0, 1'b1);
    tick(2'b00, 3'd0, 3'd0, 1'b1);
  endtask

  // Requesters hold req until their grant; a2/b2 replace the row once granted.
  // sticky keeps both requests up for the whole window.
  task automatic serve(input logic [1:0] want, input logic [2:0] a, b, a2, b2,
                       input bit sticky, input int ncyc);
    logic [1:0] pend = want;
    logic [2:0] ra = a, rb = b;
    for (int c = 0; c < ncyc; c++) begin
      tick(pend, ra, rb, 1'b0);
      if ((e_gnt & 1) != 0) begin ra = a2; if (!sticky) pend[0] = 1'b0; end
      if ((e_gnt & 2) != 0) begin rb = b2; if (!sticky) pend[1] = 1'b0; end
      if (!sticky && pend == 2'b00 && m_busy == 0) break;
    end
    if (!sticky) check("serve_done", (pend == 2'b00 && m_busy == 0) ? 1 : 0, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] pend;
    logic [2:0] ra, rb;
    logic       rs;
    int         cyc;

    // Reset state.
    do_reset();
    check("rst_row_sum", int'(row_sum), 0);
    check("rst_rd_data", int'(rd_data), 0);

    // Single requester, row 3: beats 24..31, sum 220, busy 8 cycles.
    clear_rec();
    serve(2'b01, 3'd3, 3'd0, 3'd3, 3'd0, 1'b0, 20);
    check("r3_sum",   (rec_sum.size() == 1) ? rec_sum[0] : -1, 220);
    check("r3_beats", rec_data.size(), 8);
    check("r3_first", (rec_data.size() > 0) ? rec_data[0] : -1, 24);
    check("r3_busy",  cnt_busy, 8);
    check("r3_gnts",  rec_gnt.size(), 1);

    // Both request from reset: 0 first (348), then 1 with no gap (156).
    do_reset();
    clear_rec();
    serve(2'b11, 3'd5, 3'd2, 3'd5, 3'd2, 1'b0, 30);
    check("both_n",    rec_sum.size(), 2);
    check("both_sum0", (rec_sum.size() > 0) ? rec_sum[0] : -1, 348);
    check("both_id1",  (rec_id.size()  > 1) ? rec_id[1]  : -1, 1);
    check("both_sum1", (rec_sum.size() > 1) ? rec_sum[1] : -1, 156);
    check("both_beats", rec_data.size(), 16);

    // Continuous requests: grants alternate 0,1,0,1 and busy never drops.
    do_reset();
    clear_rec();
    serve(2'b11, 3'd1, 3'd4, 3'd1, 3'd4, 1'b1, 32);
    serve(2'b00, 3'd1, 3'd4, 3'd1, 3'd4, 1'b0, 12);
    check("alt_n", rec_gnt.size(), 4);
    for (int k = 0; k < rec_gnt.size() && k < 4; k++)
      check("alt_gnt", rec_gnt[k], (k % 2 == 0) ? 1 : 2);
    check("alt_busy", cnt_busy, 32);

    // Reset in the middle of a row-7 burst, after beat 4 is visible.
    do_reset();
    clear_rec();
    tick(2'b01, 3'd7, 3'd0, 1'b0);
    cyc = 0;
    while (!(rd_valid && rd_beat == 3'd4) && cyc < 12) begin
      tick(2'b00, 3'd7, 3'd0, 1'b0);
      cyc++;
    end
    check("abort_reached", cyc < 12 ? 1 : 0, 1);
    check("abort_beat4", int'(rd_data), 60);
    tick(2'b00, 3'd7, 3'd0, 1'b1);
    tick(2'b00, 3'd7, 3'd0, 1'b0);
    tick(2'b00, 3'd7, 3'd0, 1'b0);
    check("abort_no_last", rec_sum.size(), 0);
    check("abort_last_data", (rec_data.size() > 0) ? rec_data[rec_data.size()-1] : -1, 60);
    tick(2'b10, 3'd0, 3'd2, 1'b0);
    check("abort_regrant", int'(gnt), 2);
    serve(2'b00, 3'd0, 3'd2, 3'd0, 3'd2, 1'b0, 12);

    // Row changed right after grant: burst stays on row 1 (sum 92).
    do_reset();
    clear_rec();
    serve(2'b01, 3'd1, 3'd0, 3'd6, 3'd0, 1'b0, 20);
    check("hold_sum", (rec_sum.size() == 1) ? rec_sum[0] : -1, 92);

    // Maximum cost: 8*127 = 1016 without wrap.
    do_reset();
    force127 = 1'b1;
    clear_rec();
    serve(2'b01, 3'd7, 3'd0, 3'd7, 3'd0, 1'b0, 20);
    check("max_sum", (rec_sum.size() == 1) ? rec_sum[0] : -1, 1016);

    // Randomized traffic with occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      force127 = (blk == 3);
      pend = 2'b00; ra = 3'd0; rb = 3'd0;
      for (int c = 0; c < 500; c++) begin
        rs = ($urandom_range(149) == 0);
        tick(pend, ra, rb, rs);
        if (!rs && (e_gnt & 1) != 0) begin
          pend[0] = 1'b0;
          if ($urandom_range(1) == 0) ra = 3'($urandom_range(7));
        end
        if (!rs && (e_gnt & 2) != 0) begin
          pend[1] = 1'b0;
          if ($urandom_range(1) == 0) rb = 3'($urandom_range(7));
        end
        if (!pend[0] && $urandom_range(2) == 0) begin pend[0] = 1'b1; ra = 3'($urandom_range(7)); end
        if (!pend[1] && $urandom_range(2) == 0) begin pend[1] = 1'b1; rb = 3'($urandom_range(7)); end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
